// File: rtl/ps_pkg.sv
// Program-sequencer shared definitions: stcky bit positions, ureg sub-addresses, PC-stack op decode.
// Pure declarations; no timing or flow-control behaviour of its own.
package ps_pkg;

  localparam int STCKY_EMPTY = 0;
  localparam int STCKY_FULL  = 1;
  localparam int STCKY_OVF   = 2;
  localparam int STCKY_UNF   = 3;

  localparam logic [4:0] UREG_PCSTCK = 5'b00100;
  localparam logic [4:0] UREG_PCSTKP = 5'b00101;
  localparam logic [4:0] UREG_STCKY  = 5'b11110;

  typedef enum logic [2:0] {
    OP_IDLE,
    OP_PUSH,
    OP_POP,
    OP_REPL,
    OP_TOPWR
  } stck_op_e;

  // push+pop on an empty stack degenerates to a plain push; top_wr only acts alone on a non-empty stack
  function automatic stck_op_e stck_op(input logic push, input logic pop,
                                       input logic top_wr, input logic empty);
    stck_op_e op;
    op = OP_IDLE;
    if (push && (!pop || empty)) op = OP_PUSH;
    else if (push && pop)        op = OP_REPL;
    else if (pop)                op = OP_POP;
    else if (top_wr && !empty)   op = OP_TOPWR;
    return op;
  endfunction

endpackage

// File: rtl/ps_stck_mem.sv
// PC-stack storage: DEPTHxWIDTH flop array, one synchronous write port, one combinational read port.
// Write lands on the rising edge; read reflects stored contents with zero latency; never stalls.
module ps_stck_mem #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_dat
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_addr] = wr_dat;
  end

  // contents are don't-care after reset; occupancy in the controller masks them
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_dat = mem_q[rd_addr];

endmodule

// File: rtl/ps_pcstck_ctrl.sv
// PC stack controller: call/return push/pop, ureg top overwrite, sticky ovf/unf with fetch halt.
// Requests take effect on the next edge; while ovf is set all stack ops are dropped until stcky_clr.
module ps_pcstck_ctrl
  import ps_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 8,
  localparam int PW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_dt,
  input  logic             top_wr,
  input  logic [WIDTH-1:0] top_wr_dt,
  input  logic             stcky_clr,
  output logic [WIDTH-1:0] top_dt,
  output logic [PW-1:0]    pntr,
  output logic             empty,
  output logic             full,
  output logic             ovf,
  output logic             unf,
  output logic             halt,
  output logic [3:0]       stcky
);

  localparam int            AW        = $clog2(DEPTH);
  localparam logic [PW-1:0] PNTR_FULL = PW'(DEPTH);

  logic [PW-1:0]    pntr_q, pntr_d, pntr_dec;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             ovf_set, unf_set;
  logic             empty_w, full_w;
  logic             wr_en;
  logic [AW-1:0]    wr_addr, top_addr;
  logic [WIDTH-1:0] wr_dat, rd_dat;
  stck_op_e         op;

  assign empty_w  = (pntr_q == '0);
  assign full_w   = (pntr_q == PNTR_FULL);
  assign pntr_dec = pntr_q - PW'(1);
  assign top_addr = pntr_dec[AW-1:0];

  always_comb begin
    op      = stck_op(push, pop, top_wr, empty_w);
    pntr_d  = pntr_q;
    wr_en   = 1'b0;
    wr_addr = top_addr;
    wr_dat  = push_dt;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (!ovf_q) begin
      case (op)
        OP_PUSH: begin
          if (full_w) begin
            ovf_set = 1'b1;
          end else begin
            wr_en   = 1'b1;
            wr_addr = pntr_q[AW-1:0];
            pntr_d  = pntr_q + PW'(1);
          end
        end
        OP_POP: begin
          if (empty_w) unf_set = 1'b1;
          else         pntr_d  = pntr_dec;
        end
        OP_REPL:  wr_en = 1'b1;
        OP_TOPWR: begin
          wr_en  = 1'b1;
          wr_dat = top_wr_dt;
        end
        default: ;
      endcase
    end
    // a fresh event in the clearing cycle keeps its flag set
    ovf_d = ovf_set | (ovf_q & ~stcky_clr);
    unf_d = unf_set | (unf_q & ~stcky_clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pntr_q <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      pntr_q <= pntr_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  ps_stck_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk    (clk),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_dat (wr_dat),
    .rd_addr(top_addr),
    .rd_dat (rd_dat)
  );

  always_comb begin
    stcky              = '0;
    stcky[STCKY_EMPTY] = empty_w;
    stcky[STCKY_FULL]  = full_w;
    stcky[STCKY_OVF]   = ovf_q;
    stcky[STCKY_UNF]   = unf_q;
  end

  assign top_dt = empty_w ? '0 : rd_dat;
  assign pntr   = pntr_q;
  assign empty  = empty_w;
  assign full   = full_w;
  assign ovf    = ovf_q;
  assign unf    = unf_q;
  assign halt   = ovf_q;

endmodule
